// File: rtl/dec2bin_stepper.sv
// dec2bin_stepper: paced BCD-to-binary converter using reverse double-dabble.
// One shift-and-correct step happens on each rising edge of the divided slow
// clock, so a 1 Hz divider makes the conversion visible on the board LEDs.
module dec2bin_stepper #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  slow_clk,
    input  logic                  start,
    input  logic                  abort,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic [3:0]            step,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam logic [3:0] STEP_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic slow_clk_d;
    logic tick;
    logic bcd_bad;

    logic [BCD_W-1:0]       bcd_r;
    logic [BCD_W-1:0]       bcd_next;
    logic [BCD_W-1:0]       bcd_step;
    logic [BIN_W-1:0]       bin_r;
    logic [BIN_W-1:0]       bin_next;
    logic [BIN_W-1:0]       bin_step;
    logic [BIN_W-1:0]       bin_out_next;
    logic [3:0]             step_next;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Delay the slow clock by one cycle so its rising edge becomes a one-cycle tick.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            slow_clk_d <= 1'b0;
        end else begin
            slow_clk_d <= slow_clk;
        end
    end

    assign tick = slow_clk & ~slow_clk_d;

    // Flag any incoming digit above 9; such a value cannot be converted.
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift the whole work register right, then
    // pull every BCD digit that reached 8 or more back down by 3.
    always_comb begin
        shifted  = {bcd_r, bin_r} >> 1;
        bcd_step = shifted[BIN_W +: BCD_W];
        bin_step = shifted[BIN_W-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_step[4*i +: 4] >= 4'd8) begin
                bcd_step[4*i +: 4] = bcd_step[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath decisions; abort overrides loads and ticks.
    always_comb begin
        state_next   = state;
        bcd_next     = bcd_r;
        bin_next     = bin_r;
        step_next    = step;
        bin_out_next = bin_out;
        if (abort) begin
            state_next = IDLE;
            step_next  = '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        bcd_next   = bcd_in;
                        bin_next   = '0;
                        step_next  = '0;
                        state_next = bcd_bad ? ERROR : RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        bcd_next  = bcd_step;
                        bin_next  = bin_step;
                        step_next = step + 4'd1;
                        if (step == STEP_LAST) begin
                            bin_out_next = bin_step;
                            state_next   = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, work register, step counter and result register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            step    <= '0;
            bin_out <= '0;
        end else begin
            state   <= state_next;
            bcd_r   <= bcd_next;
            bin_r   <= bin_next;
            step    <= step_next;
            bin_out <= bin_out_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign err  = (state == ERROR);

endmodule

// File: tb/tb_dec2bin_stepper.sv
// Self-checking bench for dec2bin_stepper: scripted scenarios plus a random
// phase, all compared cycle by cycle against a decimal-arithmetic reference.
module tb_dec2bin_stepper;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic                clk_in;
    logic                rst;
    logic                slow_clk;
    logic                start;
    logic                abort;
    logic [4*DIGITS-1:0] bcd_in;
    logic [BIN_W-1:0]    bin_out;
    logic [3:0]          step;
    logic                busy;
    logic                done;
    logic                err;

    typedef enum int {M_IDLE, M_RUN, M_DONE, M_ERR} mode_t;

    mode_t m_mode;
    int    m_step;
    int    m_bin_out;
    int    m_target;
    logic  prev_slow;
    int    div_cnt;
    int    compared;
    int    mismatched;

    dec2bin_stepper #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .abort    (abort),
        .bcd_in   (bcd_in),
        .bin_out  (bin_out),
        .step     (step),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Decimal value of a packed BCD word, or -1 if any digit is not 0..9.
    function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return -1;
            v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_step    = 0;
        m_bin_out = 0;
        m_target  = 0;
        prev_slow = 1'b0;
    endtask

    // Advance the reference by one clk_in edge using the inputs held across it.
    task automatic model_edge();
        logic tk;
        if (rst) begin
            model_reset();
            return;
        end
        tk = slow_clk && !prev_slow;
        prev_slow = slow_clk;
        if (abort) begin
            m_mode = M_IDLE;
            m_step = 0;
        end else if (m_mode == M_RUN) begin
            if (tk) begin
                m_step++;
                if (m_step == BIN_W) begin
                    m_bin_out = m_target;
                    m_mode    = M_DONE;
                end
            end
        end else if (start) begin
            m_step = 0;
            if (bcd_value(bcd_in) < 0) begin
                m_mode = M_ERR;
            end else begin
                m_mode   = M_RUN;
                m_target = bcd_value(bcd_in);
            end
        end
    endtask

    task automatic check_all();
        checkOutput("busy", 32'(busy), 32'(m_mode == M_RUN));
        checkOutput("done", 32'(done), 32'(m_mode == M_DONE));
        checkOutput("err", 32'(err), 32'(m_mode == M_ERR));
        checkOutput("step", 32'(step), 32'(m_step));
        checkOutput("bin_out", 32'(bin_out), 32'(m_bin_out));
    endtask

    // Drive one cycle of inputs, advance the slow-clock divider, clock and check.
    task automatic applyStimulus(input logic s, input logic a, input logic [4*DIGITS-1:0] b);
        start  = s;
        abort  = a;
        bcd_in = b;
        if (div_cnt == 3) begin
            slow_clk = ~slow_clk;
            div_cnt  = 0;
        end else begin
            div_cnt++;
        end
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, bcd_in);
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 200 && m_mode == M_RUN; i++) applyStimulus(1'b0, 1'b0, bcd_in);
        checkOutput("done_reached", 32'(done), 32'd1);
    endtask

    task automatic run_until_step(input int n);
        for (int i = 0; i < 200 && m_step < n && m_mode == M_RUN; i++) applyStimulus(1'b0, 1'b0, bcd_in);
        checkOutput("step_reached", 32'(step), 32'(n));
    endtask

    initial begin
        logic [4*DIGITS-1:0] rb;
        compared   = 0;
        mismatched = 0;
        div_cnt    = 0;
        rst        = 1'b1;
        slow_clk   = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        bcd_in     = '0;
        model_reset();

        // Reset and idle with the slow clock running.
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(24);
        checkOutput("idle_step", 32'(step), 32'd0);

        // 255 conversion.
        applyStimulus(1'b1, 1'b0, 12'h255);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        run_until_done();
        checkOutput("bin255", 32'(bin_out), 32'd255);
        checkOutput("step_full", 32'(step), 32'(BIN_W));
        idle_cycles(10);

        // 999 then 000 from DONE.
        applyStimulus(1'b1, 1'b0, 12'h999);
        run_until_done();
        checkOutput("bin999", 32'(bin_out), 32'd999);
        applyStimulus(1'b1, 1'b0, 12'h000);
        run_until_done();
        checkOutput("bin000", 32'(bin_out), 32'd0);

        // Invalid digit, then recovery with 042.
        applyStimulus(1'b1, 1'b0, 12'h1A3);
        checkOutput("err1A3", 32'(err), 32'd1);
        checkOutput("busy1A3", 32'(busy), 32'd0);
        idle_cycles(12);
        checkOutput("bin_kept", 32'(bin_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h042);
        run_until_done();
        checkOutput("bin042", 32'(bin_out), 32'd42);

        // Abort after four ticks.
        applyStimulus(1'b1, 1'b0, 12'h512);
        run_until_step(4);
        applyStimulus(1'b0, 1'b1, 12'h512);
        checkOutput("abort_step", 32'(step), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bin", 32'(bin_out), 32'd42);

        // Start coinciding with a tick: load wins, step stays 0 until the next tick.
        for (int i = 0; i < 10 && !(div_cnt == 3 && !slow_clk); i++) applyStimulus(1'b0, 1'b0, bcd_in);
        applyStimulus(1'b1, 1'b0, 12'h512);
        checkOutput("coinc_busy", 32'(busy), 32'd1);
        idle_cycles(4);
        checkOutput("coinc_step", 32'(step), 32'd0);
        run_until_done();
        checkOutput("bin512", 32'(bin_out), 32'd512);

        // Asynchronous reset after tick 7, then a fresh 100.
        applyStimulus(1'b1, 1'b0, 12'h389);
        run_until_step(7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_step", 32'(step), 32'd0);
        checkOutput("rst_bin", 32'(bin_out), 32'd0);
        @(posedge clk_in);
        #1;
        applyStimulus(1'b0, 1'b0, 12'h000);
        rst = 1'b0;
        idle_cycles(3);
        applyStimulus(1'b1, 1'b0, 12'h100);
        run_until_done();
        checkOutput("bin100", 32'(bin_out), 32'd100);

        // Random traffic: occasional starts, rare aborts, some invalid digits.
        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 7) == 0) rb[4*d +: 4] = 4'($urandom_range(10, 15));
                else rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            applyStimulus(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0), rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dec2bin_stepper.md
# dec2bin_stepper

Paced decimal-to-binary converter. Loads a packed BCD value and converts it to binary with reverse double-dabble (shift-right plus correct), performing one step per rising edge of the divided slow clock. At 1 Hz the conversion is visible on the board LEDs. The block sits directly downstream of the clock divider, consumes its `divided_clk` output as a step-enable, and runs entirely in the `clk_in` domain.

## Interface
- `DIGITS`, default 3: number of BCD digits in `bcd_in`.
- `BIN_W`, default 10: binary result width and number of conversion steps. Must satisfy 2^BIN_W ≥ 10^DIGITS.
- `clk_in`, input, 1: system clock. Every register in the block uses this clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `slow_clk`, input, 1: divided clock from the clock divider. It is a register output in the `clk_in` domain, so no synchronizer is needed.
- `start`, input, 1: level-sampled load/convert request.
- `abort`, input, 1: synchronous abort back to IDLE.
- `bcd_in`, input, 4*DIGITS: packed BCD value. Digit 0 occupies `[3:0]`.
- `bin_out`, output, BIN_W: last completed result.
- `step`, output, 4 bits (must hold BIN_W): number of steps done in the current conversion.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `err`, output, 1: high in ERROR (invalid digit).

## Operation
**Tick generation**
- `slow_clk_d` is a one-flop delay of `slow_clk`.
- `tick = slow_clk & ~slow_clk_d`.
- `tick` is high for exactly one `clk_in` cycle per slow-clock period.

**Working register**
- `work = {bcd_r[4*DIGITS-1:0], bin_r[BIN_W-1:0]}`.
- On each step, shift `work` right by 1.
- Then, for each BCD digit of the shifted value: if the digit ≥ 8, subtract 3 from it.
- Shift and correction happen in one combinational pass and one register update.

**State machine** (IDLE, RUN, DONE, ERROR)
- IDLE:
  - Outputs `busy=0`, `done=0`, `err=0`.
  - If `start=1`: capture `bcd_in` into `bcd_r`, set `bin_r=0` and `step=0`.
  - If any digit > 9, go to ERROR; otherwise go to RUN.
- RUN:
  - `busy=1`.
  - On `tick`: perform one step and set `step=step+1`.
  - On the tick where `step` goes from BIN_W-1 to BIN_W: set `bin_out <= next bin_r`, then go to DONE.
  - `start` is ignored in RUN.
- DONE:
  - `done=1`.
  - `bin_out` and `step=BIN_W` are held.
  - If `start=1`, perform the same load and check as in IDLE.
- ERROR:
  - `err=1`.
  - `bin_out` is unchanged.
  - If `start=1`, perform the same load and check as in IDLE.

**Common rules (all states)**
- `abort=1` forces IDLE and `step=0`. `bin_out` is unchanged.
- `abort` has priority over `start` and `tick`.
- `tick` in IDLE, DONE or ERROR has no effect.
- `bin_out` is written only when a conversion completes.

## Timing
**Reset values**
- State = IDLE.
- `bin_out=0`, `step=0`, `busy=0`, `done=0`, `err=0`.
- `bcd_r=0`, `bin_r=0`.
- `slow_clk_d=0`. If `slow_clk` is already high when reset releases, a tick is produced; that tick is ignored because the state is IDLE.

**Latencies**
- `start` sampled high at edge N gives state RUN/ERROR and `busy`/`err` visible after edge N.
- A `start` and a `tick` in the same cycle: the load wins, and the first step happens on the next tick.
- A `slow_clk` rising edge at edge M makes `tick` high in the cycle after edge M. The step register update is visible after edge M+1.
- Conversion time is exactly BIN_W ticks after entering RUN. With the 1 Hz divider and BIN_W=10, that is 10 s ±1 tick phase.
- `done` and the new `bin_out` become visible together, on the same `clk_in` edge that consumes the BIN_W-th tick.

**Mid-operation events**
- `rst` mid-conversion returns to the reset values immediately (asynchronous).
- `abort` mid-conversion discards the partial result.

## Test plan
Benches drive `slow_clk` from a fast toggle (e.g. every 4 `clk_in` cycles).

1. Reset, idle `start=0`, `slow_clk` toggling → outputs stay at their reset values and `step` remains 0.
2. `bcd_in=0x255`, one-cycle `start` → `busy` high for 10 ticks, `step` counts 1..10, then `done=1` and `bin_out=10'b0011111111` (255).
3. `bcd_in=0x999` converted, then from DONE `bcd_in=0x000` with `start` → first `bin_out=0x3E7`; second run ends with `bin_out=0`, `done=1`.
4. `bcd_in=0x1A3` with `start` → ERROR next cycle, `err=1`, `busy=0`, `bin_out` keeps its previous value; then `0x042` with `start` → `bin_out=42`.
5. `start` for `0x512`, `abort` after 4 ticks → IDLE, `step=0`, `bin_out` unchanged. Asserting `start` and `tick` in the same cycle → RUN is entered and `step` stays 0 until the following tick.
6. Assert `rst` after tick 7 of a conversion → all outputs return to reset values asynchronously; a fresh `0x100` conversion then yields 100.
